// File: rtl/seven_seg_pkg.sv
// Shared constants, shadow-register layout and hex-to-segment lookup for the
// 8-digit common-anode scan driver.
package seven_seg_pkg;

    localparam int unsigned NUM_DIGITS = 8;
    localparam logic [7:0]  SEG_BLANK  = 8'hFF;
    localparam logic [7:0]  AN_NONE    = 8'hFF;

    typedef struct packed {
        logic [31:0] num;
        logic [7:0]  point;
        logic [7:0]  le;
    } shadow_t;

    // Active-low {g,f,e,d,c,b,a} pattern for one hex digit.
    function automatic logic [6:0] hex2seg(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seven_seg_hex_decode.sv
// Combinational decode of one nibble plus decimal-point request into the
// active-low {dp,g,f,e,d,c,b,a} segment byte.
module seven_seg_hex_decode
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       point,
    output logic [7:0] segment
);

    always_comb begin
        segment = {~point, hex2seg(nibble)};
    end

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed 8-digit hex display driver with per-frame input snapshot,
// per-digit decimal point and blink. Optional leading-zero blanking: SEG_LZ_BLANK_EN.
module seven_seg_scan
    import seven_seg_pkg::*;
#(
    parameter int unsigned SCAN_PERIOD  = 50000,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] disp_num,
    input  logic [7:0]  point_in,
    input  logic [7:0]  le,
    output logic [7:0]  AN,
    output logic [7:0]  SEGMENT,
    output logic        frame_done
);

    localparam int unsigned PW = (SCAN_PERIOD  > 1) ? $clog2(SCAN_PERIOD)  : 1;
    localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PW-1:0] PRE_LAST   = PW'(SCAN_PERIOD - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    logic [PW-1:0] pre_cnt;
    logic [2:0]    digit;
    shadow_t       shadow;
    logic [BW-1:0] blink_cnt;
    logic          blink_phase;

    logic [3:0]    nibble;
    logic          point_cur;
    logic [7:0]    seg_byte;
    logic          blink_off;
    logic          lz_off;
    logic          digit_on;
    logic          frame_start;
    logic          slot_last;

    assign nibble      = shadow.num[{digit, 2'b00} +: 4];
    assign point_cur   = shadow.point[digit];
    assign blink_off   = blink_phase & shadow.le[digit];
    assign frame_start = (pre_cnt == '0) && (digit == 3'd0);
    assign slot_last   = (pre_cnt == PRE_LAST);

`ifdef SEG_LZ_BLANK_EN
    logic [2:0] lz_top;

    // Index of the highest nonzero nibble; digit 0 is never above it.
    always_comb begin
        lz_top = '0;
        for (int unsigned i = 1; i < NUM_DIGITS; i++) begin
            if (shadow.num[4*i +: 4] != 4'h0) begin
                lz_top = 3'(i);
            end
        end
    end

    assign lz_off = (digit > lz_top) && !point_cur;
`else
    assign lz_off = 1'b0;
`endif

    assign digit_on = ~(blink_off | lz_off);

    seven_seg_hex_decode u_decode (
        .nibble  (nibble),
        .point   (point_cur),
        .segment (seg_byte)
    );

    // Outputs use the pre-update shadow, so the first cycle of a frame still
    // shows the previous frame's digit-0 value.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt     <= '0;
            digit       <= '0;
            shadow      <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            AN          <= AN_NONE;
            SEGMENT     <= SEG_BLANK;
            frame_done  <= 1'b0;
        end else begin
            AN         <= digit_on ? ~(8'(1) << digit) : AN_NONE;
            SEGMENT    <= digit_on ? seg_byte : SEG_BLANK;
            frame_done <= slot_last && (digit == 3'd7);

            if (frame_start) begin
                shadow <= '{num: disp_num, point: point_in, le: le};
            end

            if (slot_last) begin
                pre_cnt <= '0;
                digit   <= digit + 3'd1;
            end else begin
                pre_cnt <= pre_cnt + 1'b1;
            end

            if (frame_done) begin
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
        end
    end

endmodule
